// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared constants and helpers for the UART receive path (the transmitter may
// adopt this package later).
//   - FSM state encodings (legacy-compatible localparam constants)
//   - Oversampling ratio and mid-bit sample indices
//   - Prescaler divisor calculation, 3-input majority and even-parity check
// No ports: package only.
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;

    // Mid-bit sample indices; only valid for 16x oversampling.
    localparam logic [3:0] MID_LO = 4'd7;
    localparam logic [3:0] MID    = 4'd8;
    localparam logic [3:0] MID_HI = 4'd9;

    typedef logic [2:0] rx_state_t;

    localparam rx_state_t IDLE   = 3'd0;
    localparam rx_state_t START  = 3'd1;
    localparam rx_state_t DATA   = 3'd2;
    localparam rx_state_t PARITY = 3'd3;
    localparam rx_state_t STOP   = 3'd4;
    localparam rx_state_t BREAK  = 3'd5;

    // Clock cycles per oversample tick (integer division, truncating).
    function automatic int unsigned calc_tick_div(
        input int unsigned clk_freq,
        input int unsigned baud_rate,
        input int unsigned oversample
    );
        return clk_freq / (baud_rate * oversample);
    endfunction

    // Majority of three samples.
    function automatic logic majority3(
        input logic a,
        input logic b,
        input logic c
    );
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Even parity holds when data plus parity bit carry an even number of ones.
    function automatic logic even_parity_ok(
        input logic [7:0] data,
        input logic       par_bit
    );
        return ~(^{data, par_bit});
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
// Front end of the UART receiver: two-flop synchroniser on rx, falling-edge
// detector, restartable oversample prescaler, 4-bit sample counter and the
// three-sample mid-bit majority vote.
// Ports:
//   clk            in   system clock
//   reset_n        in   asynchronous active-low reset
//   rx             in   raw asynchronous serial line (idle high)
//   restart        in   realign prescaler and sample counter to a start edge
//   rx_s           out  synchronised line level
//   fall_edge      out  rx_s went 1 -> 0 this cycle
//   decision_valid out  one-cycle strobe on the tick where samp_cnt = 9
//   bit_value      out  majority of samples at samp_cnt 7, 8, 9
// -----------------------------------------------------------------------------
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic rx,
    input  logic restart,
    output logic rx_s,
    output logic fall_edge,
    output logic decision_valid,
    output logic bit_value
);

    localparam int unsigned TICK_DIV   = calc_tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int unsigned PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    logic          meta_r;
    logic          sync_r;
    logic          prev_r;
    logic [PW-1:0] presc_r;
    logic [3:0]    samp_cnt_r;
    logic          samp_lo_r;
    logic          samp_mid_r;
    logic          tick_s;

    assign tick_s         = (presc_r == PRESC_MAX);
    assign rx_s           = sync_r;
    assign fall_edge      = prev_r & ~sync_r;
    assign decision_valid = tick_s & (samp_cnt_r == MID_HI);
    assign bit_value      = majority3(samp_lo_r, samp_mid_r, sync_r);

    // Synchroniser and edge history; all reset to the idle (high) line level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
            prev_r <= 1'b1;
        end else begin
            meta_r <= rx;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    // Prescaler and sample counter; restart phase-aligns ticks to the start edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_r    <= '0;
            samp_cnt_r <= 4'd0;
        end else if (restart) begin
            presc_r    <= '0;
            samp_cnt_r <= 4'd0;
        end else if (tick_s) begin
            presc_r    <= '0;
            samp_cnt_r <= samp_cnt_r + 4'd1;
        end else begin
            presc_r    <= presc_r + PW'(1);
        end
    end

    // Capture the first two mid-bit samples; the third is taken live at the decision
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            samp_lo_r  <= 1'b1;
            samp_mid_r <= 1'b1;
        end else if (tick_s && (samp_cnt_r == MID_LO)) begin
            samp_lo_r  <= sync_r;
        end else if (tick_s && (samp_cnt_r == MID)) begin
            samp_mid_r <= sync_r;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receiver, 8N1 by default. Oversamples the line at 16x, validates the
// start bit with glitch rejection, majority-votes each bit and hands bytes to
// the consumer through a valid/ack handshake.
// Build option: define UART_RX_PARITY_EN for 8E1 frames with parity checking;
// with it undefined parity_err is tied low.
// Ports:
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   rx           in   serial line, idle high, asynchronous to clk
//   rx_data      out  last good byte, LSB first on the wire
//   rx_valid     out  rx_data holds an unconsumed byte
//   rx_ack       in   consumer acknowledge, clears rx_valid / overrun_err
//   rx_busy      out  validated start bit until the stop-bit decision
//   frame_err    out  one-cycle pulse on a low stop bit
//   overrun_err  out  sticky, a byte completed while rx_valid was high
//   parity_err   out  one-cycle pulse on parity mismatch
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       parity_err
);

    logic       rx_s;
    logic       fall_edge_s;
    logic       decision_valid_s;
    logic       bit_value_s;
    logic       restart_s;
    logic       commit_s;
    logic       par_bad_s;

    rx_state_t  state_r;
    logic [2:0] bit_idx_r;
    logic [7:0] shift_r;
    logic       busy_r;
    logic [7:0] data_r;
    logic       valid_r;
    logic       overrun_r;
    logic       frame_err_r;

    uart_rx_sampler #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_sampler (
        .clk            (clk),
        .reset_n        (reset_n),
        .rx             (rx),
        .restart        (restart_s),
        .rx_s           (rx_s),
        .fall_edge      (fall_edge_s),
        .decision_valid (decision_valid_s),
        .bit_value      (bit_value_s)
    );

    // A start edge is only honoured while idle; BREAK ignores the held-low line.
    assign restart_s = (state_r == IDLE) & fall_edge_s;

`ifdef UART_RX_PARITY_EN
    logic parity_err_r;
    logic par_bad_r;

    assign par_bad_s  = par_bad_r;
    assign parity_err = parity_err_r;
`else
    assign par_bad_s  = 1'b0;
    assign parity_err = 1'b0;
`endif

    // A good stop bit commits the byte unless parity already rejected it
    always_comb begin
        commit_s = 1'b0;
        if ((state_r == STOP) && decision_valid_s && bit_value_s && !par_bad_s) begin
            commit_s = 1'b1;
        end else begin
            commit_s = 1'b0;
        end
    end

    // Frame FSM: start validation, data shifting, stop check and break wait
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            bit_idx_r    <= 3'd0;
            shift_r      <= 8'd0;
            busy_r       <= 1'b0;
            frame_err_r  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_r <= 1'b0;
            par_bad_r    <= 1'b0;
`endif
        end else begin
            frame_err_r  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_r <= 1'b0;
`endif
            case (state_r)
                IDLE: begin
                    if (fall_edge_s) begin
                        state_r <= START;
                    end
                end
                START: begin
                    // The next decision is a full bit later, so entering DATA now
                    // is equivalent to waiting for the sample-counter wrap.
                    if (decision_valid_s) begin
                        if (!bit_value_s) begin
                            busy_r    <= 1'b1;
                            bit_idx_r <= 3'd0;
                            state_r   <= DATA;
                        end else begin
                            state_r   <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (decision_valid_s) begin
                        shift_r   <= {bit_value_s, shift_r[7:1]};
                        bit_idx_r <= bit_idx_r + 3'd1;
                        if (bit_idx_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_r <= PARITY;
`else
                            state_r <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (decision_valid_s) begin
                        if (!even_parity_ok(shift_r, bit_value_s)) begin
                            parity_err_r <= 1'b1;
                            par_bad_r    <= 1'b1;
                        end else begin
                            par_bad_r    <= 1'b0;
                        end
                        state_r <= STOP;
                    end
                end
`endif
                STOP: begin
                    // Leaving at mid-stop lets the next start edge resync at once.
                    if (decision_valid_s) begin
                        busy_r <= 1'b0;
                        if (bit_value_s) begin
                            state_r     <= IDLE;
                        end else begin
                            frame_err_r <= 1'b1;
                            state_r     <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Output byte register and handshake; a commit beats a same-cycle ack
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_r    <= 8'd0;
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else if (commit_s) begin
            data_r  <= shift_r;
            valid_r <= 1'b1;
            if (valid_r && !rx_ack) begin
                overrun_r <= 1'b1;
            end else if (valid_r) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
        end else if (rx_ack && valid_r) begin
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end
    end

    assign rx_data     = data_r;
    assign rx_valid    = valid_r;
    assign rx_busy     = busy_r;
    assign frame_err   = frame_err_r;
    assign overrun_err = overrun_r;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx: drives whole serial frames at the nominal
// bit period and compares the receiver against a frame-level model of what a
// consumer should see (last good byte, pending flag, overrun, error counts).
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int unsigned CLK_FREQ  = 50000000;
    localparam int unsigned BAUD_RATE = 115200;
    localparam int TICK = CLK_FREQ / (BAUD_RATE * 16);
    localparam int BIT  = 16 * TICK;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun_err;
    logic       parity_err;

    uart_rx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .OVERSAMPLE (16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ack      (rx_ack),
        .rx_busy     (rx_busy),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .parity_err  (parity_err)
    );

    always #10 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Free-running cycle count and output-event monitors
    int   cyc = 0;
    int   fe_cnt = 0;
    int   pe_cnt = 0;
    int   rise_cyc = -1;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (parity_err) pe_cnt <= pe_cnt + 1;
        if (rx_valid && !prev_valid) rise_cyc <= cyc;
        prev_valid <= rx_valid;
    end

    // Reference model of consumer-visible state
    logic [7:0] exp_data = 8'h00;
    logic       exp_valid = 1'b0;
    logic       exp_overrun = 1'b0;
    int         exp_fe = 0;
    int         exp_pe = 0;

    logic busy_mid;
    logic saw_busy_hold;

    // Drive one complete frame, then update the model from the frame rules.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok,
                              input int hold_low, input int gap, output int t0);
        @(negedge clk);
        t0 = cyc;
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            if (i == 4) begin
                repeat (BIT / 2) @(negedge clk);
                busy_mid = rx_busy;
                repeat (BIT - BIT / 2) @(negedge clk);
            end else begin
                repeat (BIT) @(negedge clk);
            end
        end
`ifdef UART_RX_PARITY_EN
        rx = par_ok ? (^d) : ~(^d);
        repeat (BIT) @(negedge clk);
`endif
        rx = stop_ok ? 1'b1 : 1'b0;
        repeat (BIT) @(negedge clk);
        saw_busy_hold = 1'b0;
        for (int i = 0; i < hold_low; i++) begin
            if (rx_busy) saw_busy_hold = 1'b1;
            @(negedge clk);
        end
        rx = 1'b1;
        repeat (gap) @(negedge clk);
`ifdef UART_RX_PARITY_EN
        if (!par_ok) exp_pe++;
`else
        par_ok = 1'b1;
`endif
        if (!stop_ok) exp_fe++;
        if (stop_ok && par_ok) begin
            if (exp_valid) exp_overrun = 1'b1;
            exp_data  = d;
            exp_valid = 1'b1;
        end
    endtask

    task automatic do_ack();
        @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        if (exp_valid) begin
            exp_valid   = 1'b0;
            exp_overrun = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({rx_data, rx_valid, rx_busy, frame_err, overrun_err, parity_err} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_values: got data=%h v=%b b=%b fe=%b ov=%b pe=%b, want all 0",
                     rx_data, rx_valid, rx_busy, frame_err, overrun_err, parity_err);
        end
        reset_n = 1'b1;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic test_basic();
        int t0;
        int lat;
        send_frame(8'hA5, 1'b1, 1'b1, 0, 20, t0);
        n_vec++;
        if (busy_mid !== 1'b1) begin
            n_err++;
            $display("FAIL basic_busy: rx_busy mid-frame got %b want 1", busy_mid);
        end
        n_vec++;
        if ({rx_valid, overrun_err, rx_busy, rx_data} !== {exp_valid, exp_overrun, 1'b0, exp_data}) begin
            n_err++;
            $display("FAIL basic_byte: got v=%b ov=%b b=%b data=%h want v=%b ov=%b b=0 data=%h",
                     rx_valid, overrun_err, rx_busy, rx_data, exp_valid, exp_overrun, exp_data);
        end
        lat = rise_cyc - t0;
        n_vec++;
        if (lat < 9 * BIT + 9 * TICK || lat > 9 * BIT + 11 * TICK) begin
            n_err++;
            $display("FAIL basic_latency: got %0d cycles want %0d..%0d",
                     lat, 9 * BIT + 9 * TICK, 9 * BIT + 11 * TICK);
        end
        do_ack();
        n_vec++;
        if ({rx_valid, overrun_err} !== {exp_valid, exp_overrun}) begin
            n_err++;
            $display("FAIL basic_ack: got v=%b ov=%b want v=%b ov=%b",
                     rx_valid, overrun_err, exp_valid, exp_overrun);
        end
    endtask

    task automatic test_glitch();
        logic saw_busy;
        int   fe0;
        fe0 = fe_cnt;
        saw_busy = 1'b0;
        @(negedge clk);
        rx = 1'b0;
        repeat (3 * TICK) @(negedge clk);
        rx = 1'b1;
        for (int i = 0; i < 2 * BIT; i++) begin
            if (rx_busy || rx_valid) saw_busy = 1'b1;
            @(negedge clk);
        end
        n_vec++;
        if ({saw_busy, rx_valid, fe_cnt - fe0} !== {1'b0, exp_valid, 32'd0}) begin
            n_err++;
            $display("FAIL glitch: got busy/valid_seen=%b v=%b fe_pulses=%0d want 0 %b 0",
                     saw_busy, rx_valid, fe_cnt - fe0, exp_valid);
        end
    endtask

    task automatic test_frame_err();
        int t0;
        send_frame(8'h3C, 1'b0, 1'b1, 2 * BIT, BIT, t0);
        n_vec++;
        if (fe_cnt !== exp_fe) begin
            n_err++;
            $display("FAIL frame_err_pulse: got %0d pulses want %0d", fe_cnt, exp_fe);
        end
        n_vec++;
        if ({rx_valid, rx_data, saw_busy_hold} !== {exp_valid, exp_data, 1'b0}) begin
            n_err++;
            $display("FAIL frame_err_hold: got v=%b data=%h busy_in_break=%b want v=%b data=%h busy=0",
                     rx_valid, rx_data, saw_busy_hold, exp_valid, exp_data);
        end
        send_frame(8'h55, 1'b1, 1'b1, 0, 20, t0);
        n_vec++;
        if ({rx_valid, overrun_err, rx_data} !== {exp_valid, exp_overrun, exp_data}) begin
            n_err++;
            $display("FAIL frame_err_recover: got v=%b ov=%b data=%h want v=%b ov=%b data=%h",
                     rx_valid, overrun_err, rx_data, exp_valid, exp_overrun, exp_data);
        end
        do_ack();
    endtask

    task automatic test_back_to_back();
        int t0;
        send_frame(8'h11, 1'b1, 1'b1, 0, 0, t0);
        send_frame(8'h22, 1'b1, 1'b1, 0, 20, t0);
        n_vec++;
        if ({rx_valid, overrun_err, rx_data} !== {exp_valid, exp_overrun, exp_data}) begin
            n_err++;
            $display("FAIL b2b_overrun: got v=%b ov=%b data=%h want v=%b ov=%b data=%h",
                     rx_valid, overrun_err, rx_data, exp_valid, exp_overrun, exp_data);
        end
        do_ack();
        n_vec++;
        if ({rx_valid, overrun_err} !== {exp_valid, exp_overrun}) begin
            n_err++;
            $display("FAIL b2b_ack: got v=%b ov=%b want v=%b ov=%b",
                     rx_valid, overrun_err, exp_valid, exp_overrun);
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        @(negedge clk);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        repeat (4 * BIT + BIT / 2) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        exp_data    = 8'h00;
        exp_valid   = 1'b0;
        exp_overrun = 1'b0;
        n_vec++;
        if ({rx_data, rx_valid, rx_busy, frame_err, overrun_err, parity_err} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_mid: got data=%h v=%b b=%b fe=%b ov=%b pe=%b, want all 0",
                     rx_data, rx_valid, rx_busy, frame_err, overrun_err, parity_err);
        end
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (BIT) @(negedge clk);
        send_frame(8'h81, 1'b1, 1'b1, 0, 20, t0);
        n_vec++;
        if ({rx_valid, overrun_err, rx_data} !== {exp_valid, exp_overrun, exp_data}) begin
            n_err++;
            $display("FAIL reset_mid_recover: got v=%b ov=%b data=%h want v=%b ov=%b data=%h",
                     rx_valid, overrun_err, rx_data, exp_valid, exp_overrun, exp_data);
        end
        do_ack();
    endtask

    task automatic test_random();
        int         t0;
        logic [7:0] d;
        bit         stop_ok;
        for (int n = 0; n < 5; n++) begin
            d       = 8'($urandom);
            stop_ok = ($urandom_range(0, 3) != 0);
            send_frame(d, stop_ok, 1'b1, 0, $urandom_range(2, 60), t0);
            n_vec++;
            if ({rx_valid, overrun_err, rx_busy, rx_data} !== {exp_valid, exp_overrun, 1'b0, exp_data}) begin
                n_err++;
                $display("FAIL random_%0d: sent %h stop=%b got v=%b ov=%b b=%b data=%h want v=%b ov=%b b=0 data=%h",
                         n, d, stop_ok, rx_valid, overrun_err, rx_busy, rx_data,
                         exp_valid, exp_overrun, exp_data);
            end
            n_vec++;
            if (fe_cnt !== exp_fe) begin
                n_err++;
                $display("FAIL random_fe_%0d: got %0d frame_err pulses want %0d", n, fe_cnt, exp_fe);
            end
            if ($urandom_range(0, 1) == 1) begin
                do_ack();
                n_vec++;
                if ({rx_valid, overrun_err} !== {exp_valid, exp_overrun}) begin
                    n_err++;
                    $display("FAIL random_ack_%0d: got v=%b ov=%b want v=%b ov=%b",
                             n, rx_valid, overrun_err, exp_valid, exp_overrun);
                end
            end
        end
        do_ack();
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int t0;
        send_frame(8'h07, 1'b1, 1'b1, 0, 20, t0);
        n_vec++;
        if ({rx_valid, rx_data} !== {exp_valid, exp_data}) begin
            n_err++;
            $display("FAIL parity_good: got v=%b data=%h want v=%b data=%h",
                     rx_valid, rx_data, exp_valid, exp_data);
        end
        do_ack();
        send_frame(8'h07, 1'b1, 1'b0, 0, 20, t0);
        n_vec++;
        if ({rx_valid, overrun_err} !== {exp_valid, exp_overrun}) begin
            n_err++;
            $display("FAIL parity_bad: got v=%b ov=%b want v=%b ov=%b",
                     rx_valid, overrun_err, exp_valid, exp_overrun);
        end
    endtask
`endif

    task automatic test_parity_count();
        n_vec++;
        if (pe_cnt !== exp_pe) begin
            n_err++;
            $display("FAIL parity_err_count: got %0d pulses want %0d", pe_cnt, exp_pe);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_parity_count();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #(20ms);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver for 8N1 serial frames. It pairs with the existing UART transmitter on the RPi4 BLE link. The block synchronises the asynchronous rx line, oversamples it at 16x baud, and validates the start bit with glitch rejection. It majority-votes each bit, then presents each byte through a valid/ack handshake with frame and overrun error flags.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD_RATE, 115200, line bit rate
OVERSAMPLE, 16, sample ticks per bit; must be 16 (the mid-bit indices below assume it)

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
rx  input  1  serial line, idle high, asynchronous to clk
rx_data  output  8  last good received byte; LSB is the first bit on the wire
rx_valid  output  1  high while rx_data holds an unconsumed byte
rx_ack  input  1  consumer acknowledge; clears rx_valid
rx_busy  output  1  high from validated start bit until the stop-bit decision
frame_err  output  1  one-cycle pulse when the stop bit samples low
overrun_err  output  1  sticky; set when a byte completes while rx_valid=1; cleared by rx_ack
parity_err  output  1  one-cycle pulse on parity mismatch; tied 0 when parity is compiled out

Behaviour:
- One clock domain: clk. Reset is asynchronous, active-low (reset_n).
- Reset values: rx_data=0, rx_valid=0, rx_busy=0, frame_err=0, overrun_err=0, parity_err=0, FSM=IDLE, synchroniser flops=1.
- Synchroniser: two flops on rx. All logic uses the second flop, rx_s, which adds 2 cycles of latency.
- Tick generator:
  - TICK_DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer division; 27 at the defaults.
  - The prescaler restarts at 0 on start detection, so each tick is phase-aligned to the falling edge.
  - A 4-bit sample counter, samp_cnt, counts ticks 0..15 and wraps.
- Bit decision: majority of rx_s at samp_cnt = 7, 8 and 9, evaluated on the tick where samp_cnt=9.
- FSM:
  - IDLE: rx_s falling (prior 1, now 0) -> START; reset the prescaler and samp_cnt.
  - START: at the decision tick, majority=0 -> the start bit is valid; rx_busy=1, bit_idx=0, go to DATA at the next samp_cnt wrap. Majority=1 -> glitch; return to IDLE with no flags.
  - DATA: one decision per bit, shifted into the shift register LSB-first. After bit_idx=7 -> STOP (or PARITY if enabled).
  - STOP: at the decision tick:
    - Stop=1: commit the byte. rx_data<=shift, rx_valid<=1. If rx_valid was already 1 and rx_ack is not high that cycle, set overrun_err and overwrite rx_data. Go to IDLE (mid-stop return allows resync).
    - Stop=0: pulse frame_err, leave rx_data and rx_valid unchanged, go to BREAK.
    - rx_busy falls in the same cycle as the decision.
  - BREAK: wait for rx_s=1, then IDLE. This stops a held-low line from retriggering.
- Handshake:
  - rx_ack=1 with rx_valid=1 clears rx_valid and overrun_err on the next edge.
  - rx_ack with rx_valid=0 is ignored.
  - Commit and rx_ack in the same cycle: the commit wins. rx_valid stays 1 with the new data, and no overrun is flagged.
- Latency: rx_valid rises 1 cycle after the mid-stop decision tick, i.e. about 9.5 bit times after the start edge plus 2 synchroniser cycles.
- reset_n low mid-frame: the partial byte is discarded immediately and all outputs return to reset values.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - The frame is 8E1, with a PARITY state between DATA and STOP that samples one extra bit.
  - If XOR(data, parity bit) != 0: pulse parity_err and discard the byte (no rx_valid, no overrun). Continue to STOP for framing, and still take the BREAK path on a bad stop.
- Undefined: 8N1 only; parity_err is driven constant 0 and no PARITY state exists.

Decomposition:
- Package uart_pkg:
  - FSM state enum: IDLE, START, DATA, PARITY, STOP, BREAK.
  - Constants OVERSAMPLE=16 and MID_LO=7, MID=8, MID_HI=9.
  - A function computing TICK_DIV from CLK_FREQ and BAUD_RATE.
  - The existing transmitter may adopt the package later.
- Sub-module uart_rx_sampler:
  - Contains the synchroniser, the restartable prescaler, samp_cnt and the 3-sample majority.
  - Outputs rx_s, fall_edge, decision_valid and bit_value.
  - The FSM stays in uart_rx.

Test Plan:
- Byte 0xA5 at 115200 with proper 8N1 -> rx_data=0xA5, rx_valid rises about 9.5 bit times after the start edge; rx_busy high during the frame.
- Low glitch of 3 bit-times/16 on an idle line -> returns to IDLE; rx_valid, rx_busy and frame_err stay 0.
- Frame 0x3C with stop bit forced 0, line then held low for 2 bit times -> one frame_err pulse, rx_data keeps its previous value, no new frame until the line goes high, then 0x55 is received correctly.
- Two back-to-back bytes 0x11, 0x22 with no rx_ack -> rx_data=0x22, overrun_err=1; rx_ack clears rx_valid and overrun_err next cycle.
- reset_n low at bit 4 of 0xFF, released, then 0x81 sent -> all outputs at reset values, then rx_data=0x81.
- UART_RX_PARITY_EN defined: 0x07 with even parity bit 1 -> valid; with parity bit 0 -> parity_err pulse, rx_valid stays 0.
